line_draw_engine: RTL and testbench

//   Parametrised Bresenham line rasteriser, second generation: coordinate widths,

---
 rtl/line_draw_engine_if.sv | 32 +++
 rtl/line_draw_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_line_draw_engine.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_draw_engine_if.sv
// Handshake bundle for line_draw_engine: sequencer command/status plus
// pixel-writer request/ack. The engine connects through the slave modport.
interface line_draw_engine_if #(
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 32
);
  logic              go;
  logic [X_W-1:0]    x0;
  logic [X_W-1:0]    x1;
  logic [Y_W-1:0]    y0;
  logic [Y_W-1:0]    y1;
  logic [ADDR_W-1:0] base_addr;
  logic              skip_last;
  logic              abort;
  logic              busy;
  logic              done;
  logic              draw;
  logic              write_finish;
  logic [ADDR_W-1:0] pixel_address;
  logic [X_W:0]      pixel_count;

  modport master (
    output go, x0, x1, y0, y1, base_addr, skip_last, abort, write_finish,
    input  busy, done, draw, pixel_address, pixel_count
  );

  modport slave (
    input  go, x0, x1, y0, y1, base_addr, skip_last, abort, write_finish,
    output busy, done, draw, pixel_address, pixel_count
  );
endinterface

// File: rtl/line_draw_engine.sv
// Parametrised Bresenham line rasteriser emitting one pixel address per
// writer ack, with last-pixel skip, abort, busy flag and pixel counter.
module line_draw_engine #(
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int ADDR_W     = 32,
  parameter int PITCH_LOG2 = 10,
  parameter int BPP_LOG2   = 1
) (
  input  logic              clk,
  input  logic              resetn,
  line_draw_engine_if.slave bus
);
  localparam int CW  = (X_W > Y_W) ? X_W : Y_W;
  localparam int EW  = CW + 2;
  localparam int NW  = CW + 1;
  localparam int PCW = X_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_REQ   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic                 skip_q, skip_d;
  logic                 steep_q, steep_d, neg_q, neg_d;
  logic [CW-1:0]        maj_q, maj_d, min_q, min_d, dx_q, dx_d, dy_q, dy_d;
  logic signed [EW-1:0] err_q, err_d;
  logic [NW-1:0]        rem_q, rem_d;
  logic                 abort_pend_q, abort_pend_d;
  logic                 busy_q, busy_d, done_q, done_d, draw_q, draw_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [PCW-1:0]       count_q, count_d;

  logic [CW-1:0]        adx_s, ady_s, a0_s, a1_s, b0_s, b1_s;
  logic [CW-1:0]        maj0_s, maj1_s, min0_s, min1_s, dx_s, dy_s;
  logic                 steep_s, swap_s, neg_s;
  logic [NW-1:0]        n_s;
  logic signed [EW-1:0] err0_s;

  logic [CW-1:0]        maj_in_s, min_in_s, dx_in_s, dy_in_s;
  logic [CW-1:0]        maj_stp_s, min_stp_s, xs_s, ys_s;
  logic                 neg_in_s;
  logic signed [EW-1:0] err_in_s, e_s, err_stp_s, dx_e_s, dy_e_s;

  // Octant normalisation of the latched endpoints, used during SETUP
  always_comb begin
    adx_s   = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    ady_s   = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    steep_s = (ady_s > adx_s);
    a0_s    = steep_s ? y0_q : x0_q;
    b0_s    = steep_s ? x0_q : y0_q;
    a1_s    = steep_s ? y1_q : x1_q;
    b1_s    = steep_s ? x1_q : y1_q;
    swap_s  = (a0_s > a1_s);
    maj0_s  = swap_s ? a1_s : a0_s;
    maj1_s  = swap_s ? a0_s : a1_s;
    min0_s  = swap_s ? b1_s : b0_s;
    min1_s  = swap_s ? b0_s : b1_s;
    dx_s    = maj1_s - maj0_s;
    dy_s    = (min0_s < min1_s) ? (min1_s - min0_s) : (min0_s - min1_s);
    neg_s   = (min0_s > min1_s);
    n_s     = skip_q ? {1'b0, dx_s} : ({1'b0, dx_s} + NW'(1'b1));
    err0_s  = -$signed({2'b00, 1'b0, dx_s[CW-1:1]});
  end

  // One Bresenham step; SETUP feeds it the walk start so a swapped skip can begin one pixel in
  always_comb begin
    if (state_q == S_SETUP) begin
      maj_in_s = maj0_s;
      min_in_s = min0_s;
      err_in_s = err0_s;
      dx_in_s  = dx_s;
      dy_in_s  = dy_s;
      neg_in_s = neg_s;
    end else begin
      maj_in_s = maj_q;
      min_in_s = min_q;
      err_in_s = err_q;
      dx_in_s  = dx_q;
      dy_in_s  = dy_q;
      neg_in_s = neg_q;
    end
    dx_e_s    = $signed({2'b00, dx_in_s});
    dy_e_s    = $signed({2'b00, dy_in_s});
    e_s       = err_in_s + dy_e_s;
    maj_stp_s = maj_in_s + CW'(1'b1);
    if (!e_s[EW-1] && (e_s != {EW{1'b0}})) begin
      min_stp_s = neg_in_s ? (min_in_s - CW'(1'b1)) : (min_in_s + CW'(1'b1));
      err_stp_s = e_s - dx_e_s;
    end else begin
      min_stp_s = min_in_s;
      err_stp_s = e_s;
    end
  end

  // Next-state, datapath update and registered output decode
  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    y0_d         = y0_q;
    y1_d         = y1_q;
    base_d       = base_q;
    skip_d       = skip_q;
    steep_d      = steep_q;
    neg_d        = neg_q;
    maj_d        = maj_q;
    min_d        = min_q;
    err_d        = err_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    rem_d        = rem_q;
    abort_pend_d = abort_pend_q;
    count_d      = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          x0_d         = CW'(bus.x0);
          x1_d         = CW'(bus.x1);
          y0_d         = CW'(bus.y0);
          y1_d         = CW'(bus.y1);
          base_d       = bus.base_addr;
          skip_d       = bus.skip_last;
          count_d      = '0;
          abort_pend_d = 1'b0;
          state_d      = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        steep_d = steep_s;
        dx_d    = dx_s;
        dy_d    = dy_s;
        neg_d   = neg_s;
        rem_d   = n_s;
        if (skip_q && swap_s) begin
          maj_d = maj_stp_s;
          min_d = min_stp_s;
          err_d = err_stp_s;
        end else begin
          maj_d = maj0_s;
          min_d = min0_s;
          err_d = err0_s;
        end
        if (bus.abort || (n_s == {NW{1'b0}})) begin
          state_d = S_DONE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.write_finish) begin
          count_d = count_q + PCW'(1'b1);
          rem_d   = rem_q - NW'(1'b1);
          if ((rem_q == NW'(1'b1)) || bus.abort || abort_pend_q) begin
            state_d = S_DONE;
          end else begin
            maj_d = maj_stp_s;
            min_d = min_stp_s;
            err_d = err_stp_s;
          end
        end else begin
          abort_pend_d = abort_pend_q | bus.abort;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    draw_d = (state_d == S_REQ);
    xs_s   = steep_d ? min_d : maj_d;
    ys_s   = steep_d ? maj_d : min_d;
    if (state_d == S_REQ) begin
      addr_d = base_q + (ADDR_W'(ys_s) << PITCH_LOG2) + (ADDR_W'(xs_s) << BPP_LOG2);
    end else begin
      addr_d = addr_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      x0_q         <= '0;
      x1_q         <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      base_q       <= '0;
      skip_q       <= 1'b0;
      steep_q      <= 1'b0;
      neg_q        <= 1'b0;
      maj_q        <= '0;
      min_q        <= '0;
      err_q        <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      rem_q        <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      draw_q       <= 1'b0;
      addr_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      y0_q         <= y0_d;
      y1_q         <= y1_d;
      base_q       <= base_d;
      skip_q       <= skip_d;
      steep_q      <= steep_d;
      neg_q        <= neg_d;
      maj_q        <= maj_d;
      min_q        <= min_d;
      err_q        <= err_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      rem_q        <= rem_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      draw_q       <= draw_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.draw          = draw_q;
  assign bus.pixel_address = addr_q;
  assign bus.pixel_count   = count_q;
endmodule

// File: tb/tb_line_draw_engine.sv
// Self-checking bench for line_draw_engine: vector table, random lines against
// a textbook Bresenham model, and hand sequences for timing/abort/reset cases.
module tb_line_draw_engine;
  logic clk = 1'b0;
  logic resetn = 1'b1;

  line_draw_engine_if #(.X_W(9),  .Y_W(8),  .ADDR_W(32)) bus  ();
  line_draw_engine_if #(.X_W(11), .Y_W(10), .ADDR_W(32)) bus6 ();

  line_draw_engine #(.X_W(9), .Y_W(8), .ADDR_W(32), .PITCH_LOG2(10), .BPP_LOG2(1)) dut (
    .clk(clk), .resetn(resetn), .bus(bus));
  line_draw_engine #(.X_W(11), .Y_W(10), .ADDR_W(32), .PITCH_LOG2(12), .BPP_LOG2(2)) dut6 (
    .clk(clk), .resetn(resetn), .bus(bus6));

  always #5 clk = ~clk;

  typedef struct {
    int          x0, y0, x1, y1;
    bit          skip;
    logic [31:0] base;
    int          mode;
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_x[$];
  int          exp_y[$];
  logic [31:0] got[$];
  vec_t        tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [31:0] addr_of(input logic [31:0] base, input int x, input int y,
                                          input int p, input int b);
    return base + (32'(y) << p) + (32'(x) << b);
  endfunction

  // Reference: textbook Bresenham over the normalised octant, then drop input (x1,y1) on skip
  task automatic model_line(input int x0, input int y0, input int x1, input int y1, input bit skip);
    int a0, b0, a1, b1, t, dx, dy, f, stp, mn;
    bit steep;
    exp_x.delete();
    exp_y.delete();
    steep = iabs(y1 - y0) > iabs(x1 - x0);
    a0 = steep ? y0 : x0; b0 = steep ? x0 : y0;
    a1 = steep ? y1 : x1; b1 = steep ? x1 : y1;
    if (a0 > a1) begin
      t = a0; a0 = a1; a1 = t;
      t = b0; b0 = b1; b1 = t;
    end
    dx = a1 - a0; dy = iabs(b1 - b0); stp = (b0 < b1) ? 1 : -1;
    f = dx / 2; mn = b0;
    for (int mj = a0; mj <= a1; mj++) begin
      exp_x.push_back(steep ? mn : mj);
      exp_y.push_back(steep ? mj : mn);
      f = f - dy;
      if (f < 0) begin
        mn = mn + stp;
        f = f + dx;
      end
    end
    if (skip) begin
      for (int i = 0; i < exp_x.size(); i++) begin
        if (exp_x[i] == x1 && exp_y[i] == y1) begin
          exp_x.delete(i);
          exp_y.delete(i);
          break;
        end
      end
    end
  endtask

  task automatic go_line(input int x0, input int y0, input int x1, input int y1,
                         input bit skip, input logic [31:0] base);
    @(negedge clk);
    bus.x0 = 9'(x0); bus.y0 = 8'(y0); bus.x1 = 9'(x1); bus.y1 = 8'(y1);
    bus.skip_last = skip; bus.base_addr = base; bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    bus.x0 = 9'($urandom); bus.y0 = 8'($urandom); bus.x1 = 9'($urandom); bus.y1 = 8'($urandom);
    bus.skip_last = 1'($urandom); bus.base_addr = $urandom;
  endtask

  // mode 0: random acks, 1: ack every cycle, 2: ack every third cycle
  task automatic run_line(input int x0, input int y0, input int x1, input int y1, input bit skip,
                          input logic [31:0] base, input int mode);
    bit seen, waiting, wf;
    logic [31:0] held;
    int cyc;
    model_line(x0, y0, x1, y1, skip);
    got.delete();
    go_line(x0, y0, x1, y1, skip, base);
    seen = 1'b0; waiting = 1'b0; held = '0; cyc = 0;
    while (!seen && cyc < 3000) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.draw) begin
          if (waiting) check("addr_stable", bus.pixel_address, held);
          case (mode)
            1:       wf = 1'b1;
            2:       wf = ((cyc % 3) == 2);
            default: wf = ($urandom_range(0, 3) != 0);
          endcase
          bus.write_finish = wf;
          if (wf) got.push_back(bus.pixel_address);
          waiting = !wf;
          held = bus.pixel_address;
        end else begin
          bus.write_finish = 1'($urandom);
          waiting = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.write_finish = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("npix", 64'(got.size()), 64'(exp_x.size()));
    for (int i = 0; i < got.size() && i < exp_x.size(); i++)
      check("pix_addr", got[i], addr_of(base, exp_x[i], exp_y[i], 10, 1));
    check("pixel_count", bus.pixel_count, 64'(exp_x.size()));
    @(negedge clk);
    check("done_one_cycle", bus.done, 64'd0);
    check("busy_after_done", bus.busy, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t1x[5];
    int t1y[5];
    int xa, ya, xb, yb;
    bit seen;
    logic [31:0] held;

    tbl[0] = '{0, 0, 4, 2, 1'b0, 32'h0,         1, 5,   32'h0,         32'h808};
    tbl[1] = '{3, 9, 1, 0, 1'b0, 32'h1000_0000, 2, 10,  32'h1000_0002, 32'h1000_2406};
    tbl[2] = '{5, 5, 2, 5, 1'b1, 32'h0,         0, 3,   32'h1406,      32'h140A};
    tbl[3] = '{7, 7, 7, 7, 1'b1, 32'h0,         0, 0,   32'h0,         32'h0};
    tbl[4] = '{10, 3, 10, 3, 1'b0, 32'h100,     0, 1,   32'hD14,       32'hD14};
    tbl[5] = '{0, 0, 8, 0, 1'b1, 32'h0,         0, 8,   32'h0,         32'hE};
    tbl[6] = '{255, 200, 0, 0, 1'b0, 32'hFFFF_F000, 0, 256, 32'hFFFF_F000, 32'h0003_11FE};
    tbl[7] = '{2, 0, 0, 7, 1'b1, 32'h0,         0, 7,   32'h4,         32'h1800};
    t1x = '{0, 1, 2, 3, 4};
    t1y = '{0, 0, 1, 1, 2};

    bus.go = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    bus.base_addr = '0; bus.skip_last = 1'b0; bus.abort = 1'b0; bus.write_finish = 1'b0;
    bus6.go = 1'b0; bus6.x0 = '0; bus6.y0 = '0; bus6.x1 = '0; bus6.y1 = '0;
    bus6.base_addr = '0; bus6.skip_last = 1'b0; bus6.abort = 1'b0; bus6.write_finish = 1'b0;

    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 64'd0);
    check("rst_done", bus.done, 64'd0);
    check("rst_draw", bus.draw, 64'd0);
    check("rst_addr", bus.pixel_address, 64'd0);
    check("rst_count", bus.pixel_count, 64'd0);
    check("rst_draw6", bus6.draw, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // T1 exact timing with write_finish tied high
    bus.write_finish = 1'b1;
    go_line(0, 0, 4, 2, 1'b0, 32'h0);
    check("t1_setup_busy", bus.busy, 64'd1);
    check("t1_setup_draw", bus.draw, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_draw", bus.draw, 64'd1);
      check("t1_addr", bus.pixel_address, addr_of(32'h0, t1x[i], t1y[i], 10, 1));
    end
    @(negedge clk);
    bus.write_finish = 1'b0;
    check("t1_done", bus.done, 64'd1);
    check("t1_draw_low", bus.draw, 64'd0);
    check("t1_count", bus.pixel_count, 64'd5);
    @(negedge clk);
    check("t1_done_low", bus.done, 64'd0);
    check("t1_busy_low", bus.busy, 64'd0);

    // Vector table
    for (int v = 0; v < 8; v++) begin
      run_line(tbl[v].x0, tbl[v].y0, tbl[v].x1, tbl[v].y1, tbl[v].skip, tbl[v].base, tbl[v].mode);
      check("tbl_count", 64'(got.size()), 64'(tbl[v].exp_n));
      if (got.size() > 0 && tbl[v].exp_n > 0) begin
        check("tbl_first", got[0], tbl[v].exp_first);
        check("tbl_last", got[got.size()-1], tbl[v].exp_last);
      end
    end

    // T3 degenerate skip: done in the third cycle counting the go cycle
    go_line(7, 7, 7, 7, 1'b1, 32'h0);
    check("t3_setup_done", bus.done, 64'd0);
    @(negedge clk);
    check("t3_done", bus.done, 64'd1);
    check("t3_draw", bus.draw, 64'd0);
    check("t3_count", bus.pixel_count, 64'd0);

    // T4a abort while a write is outstanding
    go_line(0, 0, 20, 5, 1'b0, 32'h40);
    @(negedge clk);
    held = bus.pixel_address;
    check("t4_first_addr", held, 64'h40);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("t4_draw_held", bus.draw, 64'd1);
    check("t4_addr_held", bus.pixel_address, held);
    @(negedge clk);
    check("t4_draw_held2", bus.draw, 64'd1);
    bus.write_finish = 1'b1;
    @(negedge clk);
    bus.write_finish = 1'b0;
    check("t4_done", bus.done, 64'd1);
    check("t4_draw_low", bus.draw, 64'd0);
    check("t4_count", bus.pixel_count, 64'd1);

    // T4b abort during SETUP
    go_line(0, 0, 20, 5, 1'b0, 32'h0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("t4b_done", bus.done, 64'd1);
    check("t4b_draw", bus.draw, 64'd0);
    check("t4b_count", bus.pixel_count, 64'd0);

    // T4c abort together with an ack
    go_line(0, 0, 20, 5, 1'b0, 32'h0);
    @(negedge clk);
    bus.write_finish = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.write_finish = 1'b0; bus.abort = 1'b0;
    check("t4c_done", bus.done, 64'd1);
    check("t4c_count", bus.pixel_count, 64'd1);

    // T5a go while busy is ignored
    model_line(0, 0, 3, 0, 1'b0);
    go_line(0, 0, 3, 0, 1'b0, 32'h0);
    @(negedge clk);
    bus.x0 = 9'd100; bus.y0 = 8'd50; bus.x1 = 9'd200; bus.y1 = 8'd60; bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    got.delete();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        bus.write_finish = bus.draw;
        if (bus.draw) got.push_back(bus.pixel_address);
        @(negedge clk);
      end
    end
    bus.write_finish = 1'b0;
    check("t5_done_seen", 64'(seen), 64'd1);
    check("t5_count", bus.pixel_count, 64'd4);
    check("t5_npix", 64'(got.size()), 64'(exp_x.size()));
    for (int i = 0; i < got.size() && i < exp_x.size(); i++)
      check("t5_addr", got[i], addr_of(32'h0, exp_x[i], exp_y[i], 10, 1));
    @(negedge clk);
    @(negedge clk);
    check("t5_no_restart", bus.busy, 64'd0);

    // T5b reset mid-line
    go_line(0, 0, 30, 0, 1'b0, 32'h10);
    @(negedge clk);
    check("t5b_pre_draw", bus.draw, 64'd1);
    #1 resetn = 1'b0;
    #1;
    check("t5b_draw", bus.draw, 64'd0);
    check("t5b_busy", bus.busy, 64'd0);
    check("t5b_done", bus.done, 64'd0);
    check("t5b_addr", bus.pixel_address, 64'd0);
    check("t5b_count", bus.pixel_count, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("t5b_no_done", bus.done, 64'd0);

    // Random lines against the model
    for (int r = 0; r < 25; r++) begin
      xa = $urandom_range(0, 511); ya = $urandom_range(0, 255);
      xb = $urandom_range(0, 511); yb = $urandom_range(0, 255);
      run_line(xa, ya, xb, yb, 1'($urandom), $urandom, 0);
    end

    // T6 wide configuration, full-width diagonal
    model_line(0, 1023, 2047, 0, 1'b0);
    @(negedge clk);
    bus6.x0 = 11'd0; bus6.y0 = 10'd1023; bus6.x1 = 11'd2047; bus6.y1 = 10'd0;
    bus6.skip_last = 1'b0; bus6.base_addr = 32'h2000_0000; bus6.write_finish = 1'b1; bus6.go = 1'b1;
    @(negedge clk);
    bus6.go = 1'b0;
    got.delete();
    seen = 1'b0;
    for (int c = 0; c < 2200 && !seen; c++) begin
      if (bus6.done) begin
        seen = 1'b1;
      end else begin
        if (bus6.draw) got.push_back(bus6.pixel_address);
        @(negedge clk);
      end
    end
    bus6.write_finish = 1'b0;
    check("t6_done_seen", 64'(seen), 64'd1);
    check("t6_npix", 64'(got.size()), 64'd2048);
    check("t6_count", bus6.pixel_count, 64'd2048);
    if (got.size() > 0) check("t6_last", got[got.size()-1], 64'h2000_1FFC);
    for (int i = 0; i < got.size() && i < exp_x.size(); i++)
      check("t6_addr", got[i], addr_of(32'h2000_0000, exp_x[i], exp_y[i], 12, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
